// File: rtl/adder_pkg.sv
// Shared constants and 4-bit carry-lookahead equations for the 64-bit adder.
package adder_pkg;

  localparam int unsigned ADDER_W     = 64;
  localparam int unsigned ADDER_GRP_W = 4;
  localparam int unsigned ADDER_NGRP  = ADDER_W / ADDER_GRP_W;

  typedef logic [ADDER_W-1:0] word_t;

  // Carry into each of four positions, fully expanded so no ripple remains.
  function automatic logic [3:0] cla_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic cla_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic cla_prop(input logic [3:0] p);
    return &p;
  endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead group: sum plus group generate/propagate for the next level.
module adder_cla4
  import adder_pkg::*;
(
  input  logic [ADDER_GRP_W-1:0] a_i,
  input  logic [ADDER_GRP_W-1:0] b_i,
  input  logic                   c_i,
  output logic [ADDER_GRP_W-1:0] sum_o,
  output logic                   g_o,
  output logic                   p_o
);

  logic [ADDER_GRP_W-1:0] g;
  logic [ADDER_GRP_W-1:0] p;
  logic [ADDER_GRP_W-1:0] c;

  assign g     = a_i & b_i;
  assign p     = a_i ^ b_i;
  assign c     = cla_carry(g, p, c_i);
  assign sum_o = p ^ c;
  assign g_o   = cla_gen(g, p);
  assign p_o   = cla_prop(p);

endmodule

// File: rtl/adder.sv
// 64-bit two-level CLA adder (16 x 4-bit groups, 4x4 second level).
// Define ADDER_OUT_REG_EN to register both outputs (1-cycle latency, sync reset).
module adder
  import adder_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cIn_1,
  input  logic [ADDER_W-1:0] i_adderOperand1_64,
  input  logic [ADDER_W-1:0] i_adderOperand2_64,
  output logic [ADDER_W-1:0] o_adderSum_64,
  output logic               o_cOut_1
);

  logic [ADDER_NGRP-1:0] grp_g;
  logic [ADDER_NGRP-1:0] grp_p;
  logic [ADDER_NGRP-1:0] grp_c;
  logic [3:0]            sup_g;
  logic [3:0]            sup_p;
  logic [3:0]            sup_c;
  word_t                 sum_d;
  logic                  cout_d;

  for (genvar gi = 0; gi < ADDER_NGRP; gi++) begin : g_grp
    adder_cla4 u_cla4 (
      .a_i   (i_adderOperand1_64[gi*ADDER_GRP_W +: ADDER_GRP_W]),
      .b_i   (i_adderOperand2_64[gi*ADDER_GRP_W +: ADDER_GRP_W]),
      .c_i   (grp_c[gi]),
      .sum_o (sum_d[gi*ADDER_GRP_W +: ADDER_GRP_W]),
      .g_o   (grp_g[gi]),
      .p_o   (grp_p[gi])
    );
  end

  // Super-group G/P: each covers four groups (16 bits).
  always_comb begin
    sup_g = '0;
    sup_p = '0;
    for (int s = 0; s < 4; s++) begin
      sup_g[s] = cla_gen(grp_g[s*4 +: 4], grp_p[s*4 +: 4]);
      sup_p[s] = cla_prop(grp_p[s*4 +: 4]);
    end
  end

  assign sup_c  = cla_carry(sup_g, sup_p, i_cIn_1);
  assign cout_d = cla_gen(sup_g, sup_p) | (cla_prop(sup_p) & i_cIn_1);

  always_comb begin
    grp_c = '0;
    for (int s = 0; s < 4; s++) begin
      grp_c[s*4 +: 4] = cla_carry(grp_g[s*4 +: 4], grp_p[s*4 +: 4], sup_c[s]);
    end
  end

`ifdef ADDER_OUT_REG_EN
  word_t sum_q;
  logic  cout_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign o_adderSum_64 = sum_q;
  assign o_cOut_1      = cout_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = i_clk ^ i_rst_n;

  assign o_adderSum_64 = sum_d;
  assign o_cOut_1      = cout_d;
`endif

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: driver queues expected {cout,sum}, monitor pops and compares.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cin;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] sum;
  logic        cout;

  logic [64:0] exp_q[$];
  string       name_q[$];
  logic [64:0] last_exp;
  bit          have_last = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  adder u_dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_cIn_1            (cin),
    .i_adderOperand1_64 (op_a),
    .i_adderOperand2_64 (op_b),
    .o_adderSum_64      (sum),
    .o_cOut_1           (cout)
  );

  task automatic check(input string nm, input logic [64:0] got, input logic [64:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h",
               nm, got[64], got[63:0], want[64], want[63:0]);
    end
  endtask

  // Inputs change on the falling edge; the result is due at the next rising edge.
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic rn, input logic [64:0] want, input string nm);
    logic [64:0] w;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    rst_n = rn;
    w     = want;
`ifdef ADDER_OUT_REG_EN
    if (!rn) w = '0;
`endif
    exp_q.push_back(w);
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      last_exp = exp_q.pop_front();
      check(name_q.pop_front(), {cout, sum}, last_exp);
      have_last = 1'b1;
    end
  end

`ifdef ADDER_OUT_REG_EN
  // Registered outputs must not follow the freshly driven operands before the edge.
  always @(negedge clk) begin
    #1;
    if (have_last) check("hold_latency", {cout, sum}, last_exp);
  end
`endif

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    rst_n = 1'b0;
    cin   = 1'b0;
    op_a  = '0;
    op_b  = '0;

    apply(64'h0, 64'h0, 1'b0, 1'b0, 65'h0, "reset");
    apply(64'h0, 64'h0, 1'b0, 1'b1, 65'h0, "zero");
    apply(64'h0, 64'h0, 1'b1, 1'b1, 65'h1, "zero_cin");
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, {1'b1, 64'h0}, "full_ripple");
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
          {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, "max_ops");
    apply(64'hF, 64'h1, 1'b0, 1'b1, 65'h10, "grp_boundary");
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, {1'b0, 64'h8000_0000_0000_0000},
          "msb_boundary");
    apply(64'h5, ~64'd7, 1'b1, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, "subtract");
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, {1'b1, 64'h0},
          "top_wrap");
    apply(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 65'h1_0000_0000, "super_boundary");
    apply(64'hFFF0, 64'h10, 1'b0, 1'b1, 65'h1_0000, "group_chain");
    apply(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1,
          {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, "all_prop");
    apply(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, {1'b1, 64'h0},
          "all_prop_cin");
    apply(64'h1234, 64'h1, 1'b0, 1'b0, 65'h1235, "mid_reset");
    apply(64'h10, 64'h20, 1'b1, 1'b1, 65'h31, "after_reset");

    for (int i = 0; i < 120; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      apply(ra, rb, rc, 1'b1, {1'b0, ra} + {1'b0, rb} + {64'h0, rc}, "random");
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
